// File: rtl/bcd_digits_to_binary.sv
// Purpose: serial MSD-first BCD digit entry -> unsigned binary value (acc*10+d, mod 2^W).
// Latency: valor_valid rises one cycle after the final digit is accepted.
// Backpressure: result held in SALIDA until valor_ready; digito_ready=0 while holding.
// Optional feature: define BCD_DIGIT_CHECK_EN to add a sticky 'error' flag for digits > 9.
module bcd_digits_to_binary #(
    parameter int NDIG = 3,
    parameter int W    = 10,
    localparam int CW  = $clog2(NDIG + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [3:0]    digito,
    input  logic          digito_valid,
    input  logic          digito_last,
    output logic          digito_ready,
    input  logic          abortar,
    output logic [W-1:0]  valor,
    output logic [CW-1:0] ndig,
    output logic          valor_valid,
    input  logic          valor_ready
`ifdef BCD_DIGIT_CHECK_EN
    ,output logic         error
`endif
);

    typedef enum logic [0:0] {
        ACUM   = 1'b0,
        SALIDA = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_valor;
    logic [CW-1:0] r_ndig;

    logic          w_accept;
    logic          w_done;
    logic          w_consume;
    logic [CW-1:0] w_cnt_inc;
    logic [W-1:0]  w_nxt;

    // acc*10 + digit as shift-add in a single adder stage, wrapping at W bits
    assign w_nxt     = (r_acc << 3) + (r_acc << 1) + W'(digito);
    assign w_cnt_inc = r_cnt + CW'(1);

    // Handshake decode and next-state selection; abortar overrides everything
    always_comb begin
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_consume   = 1'b0;
        w_state_nxt = r_state;
        unique case (r_state)
            ACUM: begin
                w_accept = digito_valid;
                w_done   = digito_valid & (digito_last | (w_cnt_inc == CW'(NDIG)));
                if (w_done) w_state_nxt = SALIDA;
            end
            SALIDA: begin
                w_consume = valor_ready;
                if (valor_ready) w_state_nxt = ACUM;
            end
            default: w_state_nxt = ACUM;
        endcase
        if (abortar) begin
            w_state_nxt = ACUM;
            w_accept    = 1'b0;
            w_done      = 1'b0;
            w_consume   = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ACUM;
        else          r_state <= w_state_nxt;
    end

    // Accumulator, digit count and held result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_valor <= '0;
            r_ndig  <= '0;
        end else if (abortar) begin
            // held valor/ndig are left as-is; only their validity is dropped
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_done) begin
                r_valor <= w_nxt;
                r_ndig  <= w_cnt_inc;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else begin
                r_acc <= w_nxt;
                r_cnt <= w_cnt_inc;
            end
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic w_bad;
    logic r_err_pend;
    logic r_error;

    assign w_bad = (digito > 4'd9);

    // Sticky bad-digit tracking: pending while accumulating, presented with the result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_pend <= 1'b0;
            r_error    <= 1'b0;
        end else if (abortar) begin
            r_err_pend <= 1'b0;
            r_error    <= 1'b0;
        end else if (w_accept) begin
            if (w_done) begin
                r_error    <= r_err_pend | w_bad;
                r_err_pend <= 1'b0;
            end else begin
                r_err_pend <= r_err_pend | w_bad;
            end
        end else if (w_consume) begin
            r_error <= 1'b0;
        end
    end

    assign error = r_error;
`endif

    assign digito_ready = (r_state == ACUM);
    assign valor_valid  = (r_state == SALIDA);
    assign valor        = r_valor;
    assign ndig         = r_ndig;

endmodule

// File: tb/tb_bcd_digits_to_binary.sv
// Directed bench for bcd_digits_to_binary (NDIG=3, W=10).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Covers BCD_DIGIT_CHECK_EN when the macro is defined for the build.
module tb_bcd_digits_to_binary;

    logic       clk;
    logic       reset_n;
    logic [3:0] digito;
    logic       digito_valid;
    logic       digito_last;
    logic       digito_ready;
    logic       abortar;
    logic [9:0] valor;
    logic [1:0] ndig;
    logic       valor_valid;
    logic       valor_ready;
`ifdef BCD_DIGIT_CHECK_EN
    logic       error;
`endif

    int n_vec = 0;
    int n_err = 0;

    bcd_digits_to_binary #(.NDIG(3), .W(10)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .digito       (digito),
        .digito_valid (digito_valid),
        .digito_last  (digito_last),
        .digito_ready (digito_ready),
        .abortar      (abortar),
        .valor        (valor),
        .ndig         (ndig),
        .valor_valid  (valor_valid),
        .valor_ready  (valor_ready)
`ifdef BCD_DIGIT_CHECK_EN
        ,.error       (error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // present one digit for exactly one edge (caller ensures digito_ready=1)
    task automatic send(input logic [3:0] d, input logic last);
        digito       = d;
        digito_last  = last;
        digito_valid = 1'b1;
        tick();
        digito_valid = 1'b0;
        digito_last  = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        digito       = 4'd0;
        digito_valid = 1'b0;
        digito_last  = 1'b0;
        abortar      = 1'b0;
        valor_ready  = 1'b1;
        #2;
        chk("rst_valor", 32'(valor), 0);
        chk("rst_ndig", 32'(ndig), 0);
        chk("rst_valid", 32'(valor_valid), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_ready", 32'(digito_ready), 1);

        // 2,5,5 -> 255, valid for exactly one cycle
        send(4'd2, 1'b0);
        send(4'd5, 1'b0);
        chk("255_novalid_mid", 32'(valor_valid), 0);
        send(4'd5, 1'b1);
        chk("255_valid", 32'(valor_valid), 1);
        chk("255_valor", 32'(valor), 255);
        chk("255_ndig", 32'(ndig), 3);
        chk("255_ready_low", 32'(digito_ready), 0);
        tick();
        chk("255_valid_drop", 32'(valor_valid), 0);
        chk("255_ready_back", 32'(digito_ready), 1);

        // single digit with last
        send(4'd7, 1'b1);
        chk("7_valor", 32'(valor), 7);
        chk("7_ndig", 32'(ndig), 1);
        tick();

        // 9,9,9 without last: auto-terminates on third digit
        send(4'd9, 1'b0);
        send(4'd9, 1'b0);
        chk("999_novalid_mid", 32'(valor_valid), 0);
        send(4'd9, 1'b0);
        chk("999_valid", 32'(valor_valid), 1);
        chk("999_valor", 32'(valor), 999);
        chk("999_ndig", 32'(ndig), 3);
        tick();

        // leading zeros counted
        send(4'd0, 1'b0);
        send(4'd0, 1'b0);
        send(4'd9, 1'b0);
        chk("009_valor", 32'(valor), 9);
        chk("009_ndig", 32'(ndig), 3);
        tick();

        // 4,2 held under backpressure while next digit waits
        valor_ready = 1'b0;
        send(4'd4, 1'b0);
        send(4'd2, 1'b1);
        digito       = 4'd1;
        digito_last  = 1'b1;
        digito_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("42_hold_valid", 32'(valor_valid), 1);
            chk("42_hold_valor", 32'(valor), 42);
            chk("42_hold_ready", 32'(digito_ready), 0);
            tick();
        end
        chk("42_hold_ndig", 32'(ndig), 2);
        valor_ready = 1'b1;
        tick();
        chk("42_consumed", 32'(valor_valid), 0);
        chk("42_ready_back", 32'(digito_ready), 1);
        tick();
        digito_valid = 1'b0;
        digito_last  = 1'b0;
        chk("1_after_hold_valid", 32'(valor_valid), 1);
        chk("1_after_hold_valor", 32'(valor), 1);
        chk("1_after_hold_ndig", 32'(ndig), 1);
        tick();

        // 3,1 then abort: partial discarded
        send(4'd3, 1'b0);
        send(4'd1, 1'b0);
        abortar = 1'b1;
        tick();
        abortar = 1'b0;
        chk("abort_valid", 32'(valor_valid), 0);
        chk("abort_ready", 32'(digito_ready), 1);
        send(4'd6, 1'b1);
        chk("6_valor", 32'(valor), 6);
        chk("6_ndig", 32'(ndig), 1);
        tick();

        // abort while holding: result dropped, value left in place
        valor_ready = 1'b0;
        send(4'd8, 1'b1);
        chk("8_valid", 32'(valor_valid), 1);
        abortar = 1'b1;
        tick();
        abortar = 1'b0;
        chk("8_abort_valid", 32'(valor_valid), 0);
        chk("8_abort_valor", 32'(valor), 8);
        chk("8_abort_ready", 32'(digito_ready), 1);

        // digits above 9 used arithmetically: 15,15,15 -> 1665 mod 1024 = 641
        valor_ready = 1'b1;
        send(4'd15, 1'b0);
        send(4'd15, 1'b0);
        send(4'd15, 1'b0);
        chk("wrap_valor", 32'(valor), 641);
        tick();

        // async reset while holding 123
        valor_ready = 1'b0;
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        send(4'd3, 1'b1);
        chk("123_valor", 32'(valor), 123);
        chk("123_valid", 32'(valor_valid), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_valor", 32'(valor), 0);
        chk("arst_valid", 32'(valor_valid), 0);
        chk("arst_ndig", 32'(ndig), 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("arst_ready", 32'(digito_ready), 1);
        chk("arst_valid_after", 32'(valor_valid), 0);

        // 1,C -> 10+12 = 22
        valor_ready = 1'b1;
        send(4'd1, 1'b0);
        send(4'hC, 1'b1);
        chk("1C_valor", 32'(valor), 22);
`ifdef BCD_DIGIT_CHECK_EN
        chk("1C_error", 32'(error), 1);
`endif
        tick();
        send(4'd5, 1'b1);
        chk("5_valor", 32'(valor), 5);
`ifdef BCD_DIGIT_CHECK_EN
        chk("5_error", 32'(error), 0);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
